// File: rtl/trace_logger_param.sv
// trace_logger_param: trace capture with circular pre/post-trigger capture or streaming FIFO mode.
// Rev 1.0 - initial parametrised release.
`timescale 1ns/1ps
`default_nettype none

module trace_logger_param #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int DELAY_BITS = 3,
  parameter int DROP_BITS  = 16
) (
  input  logic                      CLK_I,
  input  logic                      RST_NI,
  input  logic                      ARM_I,
  input  logic                      CFG_MODE_I,
  input  logic [DELAY_BITS-1:0]     CFG_DELAY_I,
  input  logic                      TRG_EVENT_I,
  input  logic                      STORE_I,
  input  logic [WIDTH-1:0]          DATA_I,
  output logic                      STORE_PERM_O,
  output logic                      MEM_WE_O,
  output logic [$clog2(DEPTH)-1:0]  MEM_WADDR_O,
  output logic [WIDTH-1:0]          MEM_WDATA_O,
  output logic [$clog2(DEPTH)-1:0]  MEM_RADDR_O,
  input  logic [WIDTH-1:0]          MEM_RDATA_I,
  input  logic                      LOAD_REQUEST_I,
  output logic                      LOAD_GRANT_O,
  output logic [WIDTH-1:0]          DATA_O,
  output logic                      DATA_VALID_O,
  output logic [2:0]                STATE_O,
  output logic [$clog2(DEPTH)-1:0]  EVENT_ADDR_O,
  output logic                      TRG_DELAYED_O,
  output logic [$clog2(DEPTH+1)-1:0] FILL_O,
  output logic                      WRAPPED_O,
  output logic [DROP_BITS-1:0]      DROP_CNT_O
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam int LW = AW + DELAY_BITS + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    POST   = 3'd2,
    DONE   = 3'd3,
    STREAM = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         wptr, rptr, event_addr;
  logic [FW-1:0]         fill;
  logic                  wrapped;
  logic [LW-1:0]         post_cnt, post_len;
  logic [DROP_BITS-1:0]  drop_cnt;
  logic                  trg_delayed, rd_pending;
  logic [WIDTH-1:0]      data_hold;
  logic                  store_perm, readable, write_en, grant, full, trig, post_done;

  // Post-trigger length scales DEPTH-1 by (delay+1)/2^DELAY_BITS, so it never exceeds DEPTH-1.
  assign post_len  = ((LW'(CFG_DELAY_I) + LW'(1)) * LW'(DEPTH - 1)) >> DELAY_BITS;
  assign full      = (fill == FW'(DEPTH));
  assign trig      = (state == PRE) && TRG_EVENT_I && !ARM_I;
  assign post_done = (state == POST) && (post_cnt == '0);

  always_comb begin
    state_nxt  = state;
    store_perm = 1'b0;
    readable   = 1'b0;
    case (state)
      PRE: begin
        store_perm = 1'b1;
        if (TRG_EVENT_I) state_nxt = POST;
      end
      POST: begin
        store_perm = (post_cnt != '0);
        if (post_cnt == '0) state_nxt = DONE;
      end
      DONE:   readable = (fill != '0);
      STREAM: begin
        store_perm = !full;
        readable   = (fill != '0);
      end
      default: ;
    endcase
    // An arm cycle restarts capture; a store arriving with it is dropped silently.
    if (ARM_I) begin
      store_perm = 1'b0;
      state_nxt  = CFG_MODE_I ? STREAM : PRE;
    end
  end

  assign write_en = STORE_I && store_perm;
  assign grant    = LOAD_REQUEST_I && readable;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      event_addr  <= '0;
      fill        <= '0;
      wrapped     <= 1'b0;
      post_cnt    <= '0;
      drop_cnt    <= '0;
      trg_delayed <= 1'b0;
      rd_pending  <= 1'b0;
      data_hold   <= '0;
    end else begin
      state      <= state_nxt;
      rd_pending <= grant;
      if (rd_pending) data_hold <= MEM_RDATA_I;

      if (ARM_I) begin
        wptr        <= '0;
        rptr        <= '0;
        event_addr  <= '0;
        fill        <= '0;
        wrapped     <= 1'b0;
        post_cnt    <= '0;
        drop_cnt    <= '0;
        trg_delayed <= 1'b0;
      end else begin
        if (write_en) begin
          wptr <= wptr + 1'b1;
          if (wptr == AW'(DEPTH - 1)) wrapped <= 1'b1;
        end
        if (grant) rptr <= rptr + 1'b1;

        // Overwrite in trace mode keeps FILL pinned at DEPTH.
        if (write_en && !grant && !full)  fill <= fill + FW'(1);
        else if (grant && !write_en)      fill <= fill - FW'(1);

        if (trig) begin
          event_addr <= wptr;
          post_cnt   <= post_len;
        end else if ((state == POST) && write_en) begin
          post_cnt <= post_cnt - LW'(1);
        end

        // Readout starts at the oldest surviving entry.
        if (post_done) begin
          trg_delayed <= 1'b1;
          rptr        <= wrapped ? wptr : '0;
        end

        if ((state == STREAM) && STORE_I && !store_perm && (drop_cnt != {DROP_BITS{1'b1}}))
          drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign STORE_PERM_O  = store_perm;
  assign MEM_WE_O      = write_en;
  assign MEM_WADDR_O   = wptr;
  assign MEM_WDATA_O   = DATA_I;
  assign MEM_RADDR_O   = rptr;
  assign LOAD_GRANT_O  = grant;
  assign DATA_VALID_O  = rd_pending;
  assign DATA_O        = rd_pending ? MEM_RDATA_I : data_hold;
  assign STATE_O       = state;
  assign EVENT_ADDR_O  = event_addr;
  assign TRG_DELAYED_O = trg_delayed;
  assign FILL_O        = fill;
  assign WRAPPED_O     = wrapped;
  assign DROP_CNT_O    = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trace_logger_param.sv
// tb_trace_logger_param: randomized bench for trace_logger_param against a queue-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_trace_logger_param;
  localparam int WIDTH = 32, DEPTH = 16, DELAY_BITS = 3, DROP_BITS = 16;
  localparam int AW = $clog2(DEPTH), FW = $clog2(DEPTH+1);

  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, mode = 1'b0, trg = 1'b0, store = 1'b0, req = 1'b0;
  logic [DELAY_BITS-1:0] delay = '0;
  logic [WIDTH-1:0] din = '0;

  logic                 store_perm, mem_we, grant, dvalid, trgd, wrapped;
  logic [AW-1:0]        waddr, raddr, ev_addr;
  logic [WIDTH-1:0]     wdata, dout;
  logic [WIDTH-1:0]     mem_rdata;
  logic [2:0]           state;
  logic [FW-1:0]        fill;
  logic [DROP_BITS-1:0] drops;

  always #5 clk = ~clk;

  trace_logger_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_BITS(DELAY_BITS), .DROP_BITS(DROP_BITS)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .ARM_I(arm), .CFG_MODE_I(mode), .CFG_DELAY_I(delay),
    .TRG_EVENT_I(trg), .STORE_I(store), .DATA_I(din), .STORE_PERM_O(store_perm),
    .MEM_WE_O(mem_we), .MEM_WADDR_O(waddr), .MEM_WDATA_O(wdata), .MEM_RADDR_O(raddr),
    .MEM_RDATA_I(mem_rdata), .LOAD_REQUEST_I(req), .LOAD_GRANT_O(grant), .DATA_O(dout),
    .DATA_VALID_O(dvalid), .STATE_O(state), .EVENT_ADDR_O(ev_addr), .TRG_DELAYED_O(trgd),
    .FILL_O(fill), .WRAPPED_O(wrapped), .DROP_CNT_O(drops)
  );

  // Simple dual-port trace memory with one cycle read latency.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
    mem_rdata <= mem[raddr];
  end

  int n_checks = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: contents held oldest-first in a queue, pointers derived from write totals.
  int               m_st, m_total, m_ev, m_left, m_drops, post_we;
  bit               m_trgd, m_vld;
  logic [WIDTH-1:0] m_dout;
  logic [WIDTH-1:0] m_q[$];

  initial post_we = 0;

  always @(negedge clk) begin : compare
    bit perm, we, rd, gnt;
    int ost, old_total;
    if (!rst_n) begin
      m_st = 0; m_total = 0; m_ev = 0; m_left = 0; m_drops = 0;
      m_trgd = 0; m_vld = 0; m_dout = '0; m_q.delete();
      chk("rst_state", state, 0);
      chk("rst_fill", fill, 0);
      chk("rst_valid", dvalid, 0);
      chk("rst_we", mem_we, 0);
    end else begin
      case (m_st)
        1:       perm = 1'b1;
        2:       perm = (m_left != 0);
        4:       perm = (m_q.size() != DEPTH);
        default: perm = 1'b0;
      endcase
      if (arm) perm = 1'b0;
      we  = store && perm;
      rd  = (m_st == 3 || m_st == 4) && (m_q.size() != 0);
      gnt = req && rd;

      chk("state", state, m_st);
      chk("store_perm", store_perm, perm);
      chk("mem_we", mem_we, we);
      chk("waddr", waddr, m_total % DEPTH);
      chk("grant", grant, gnt);
      chk("fill", fill, m_q.size());
      chk("wrapped", wrapped, m_total >= DEPTH);
      chk("event_addr", ev_addr, m_ev);
      chk("trg_delayed", trgd, m_trgd);
      chk("drop_cnt", drops, m_drops);
      chk("data_valid", dvalid, m_vld);
      chk("data_out", dout, m_dout);
      if (m_st == 2 && mem_we) post_we++;

      ost = m_st;
      old_total = m_total;
      m_vld = gnt;
      if (gnt) m_dout = m_q.pop_front();
      if (arm) begin
        m_st = mode ? 4 : 1; m_total = 0; m_ev = 0; m_left = 0; m_drops = 0;
        m_trgd = 0; m_q.delete();
      end else begin
        if (we) begin
          m_q.push_back(din);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          m_total++;
        end
        if (ost == 1 && trg) begin
          m_ev   = old_total % DEPTH;
          m_left = ((int'(delay) + 1) * (DEPTH - 1)) >> DELAY_BITS;
          m_st   = 2;
        end else if (ost == 2) begin
          if (m_left == 0) begin m_st = 3; m_trgd = 1; end
          else if (we) m_left--;
        end
        if (ost == 4 && store && !perm)
          m_drops = (m_drops == 65535) ? 65535 : m_drops + 1;
      end
    end
  end

  task automatic cyc(input bit a, input bit t, input bit s, input logic [WIDTH-1:0] d, input bit r);
    arm = a; trg = t; store = s; din = d; req = r;
    @(posedge clk); #2;
  endtask

  logic [WIDTH-1:0] rd_q[$];
  logic [WIDTH-1:0] words[17];
  int base;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Asynchronous reset in the middle of a streaming run.
    mode = 1'b1;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, $urandom, 0);
    @(posedge clk); #3;
    rst_n = 1'b0; store = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_fill", fill, 0);
    chk("async_perm", store_perm, 0);
    chk("async_we", mem_we, 0);
    chk("async_wrapped", wrapped, 0);
    cyc(0, 0, 1, 32'h55, 0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 32'h66, 0);
    store = 1'b1; #1;
    chk("idle_store_we", mem_we, 0);
    cyc(0, 0, 0, 0, 0);

    // Trace mode, delay 3: trigger just before word 10.
    mode = 1'b0; delay = 3'd3;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, i, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 10; i <= 20; i++) cyc(0, 0, 1, i, 0);
    chk("t2_state", state, 3);
    chk("t2_event_addr", ev_addr, 10);
    chk("t2_fill", fill, 16);
    chk("t2_wrapped", wrapped, 1);
    chk("t2_trg_delayed", trgd, 1);
    rd_q.delete();
    for (int k = 0; k < 17; k++) begin
      if (k == 16) begin req = 1'b1; #1 chk("t2_no_17th_grant", grant, 0); end
      cyc(0, 0, 0, 0, 1);
      if (dvalid) rd_q.push_back(dout);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t2_read_count", rd_q.size(), 16);
    chk("t2_first_word", rd_q[0], 1);
    chk("t2_last_word", rd_q[15], 16);

    // Post-trigger lengths at the delay extremes; trigger coincides with a store.
    for (int v = 0; v < 2; v++) begin
      delay = (v == 0) ? 3'd0 : 3'd7;
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < ((v == 0) ? 5 : 20); i++) cyc(0, 0, 1, $urandom, 0);
      base = post_we;
      cyc(0, 1, 1, $urandom, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, $urandom, 0);
      chk(v == 0 ? "t3_post_writes_d0" : "t3_post_writes_d7", post_we - base, (v == 0) ? 1 : 15);
      chk(v == 0 ? "t3_event_d0" : "t3_event_d7", ev_addr, (v == 0) ? 5 : 4);
      for (int k = 0; k < 17; k++) cyc(0, 0, 0, 0, 1);
    end

    // Streaming: overflow by one, then a single read.
    mode = 1'b1;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin words[i] = $urandom; cyc(0, 0, 1, words[i], 0); end
    chk("t4_fill", fill, 16);
    chk("t4_perm_full", store_perm, 0);
    chk("t4_drops", drops, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_perm_after_read", store_perm, 1);
    chk("t4_valid", dvalid, 1);
    chk("t4_data", dout, words[0]);

    // Streaming: concurrent store and read at FILL=8, through pointer wrap.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, $urandom, 0);
    cyc(0, 0, 1, $urandom, 1);
    chk("t5_fill_steady", fill, 8);
    for (int i = 0; i < 31; i++) cyc(0, 0, 1, $urandom, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);

    // Re-arm from DONE into streaming mode.
    mode = 1'b0; delay = 3'd0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, $urandom, 0);
    cyc(0, 1, 1, $urandom, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, $urandom, 0);
    chk("t6_in_done", state, 3);
    mode = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("t6_state", state, 4);
    chk("t6_fill", fill, 0);
    chk("t6_drops", drops, 0);
    chk("t6_trg_delayed", trgd, 0);

    // Random traffic across all modes.
    for (int i = 0; i < 600; i++) begin
      mode  = $urandom_range(0, 1);
      delay = DELAY_BITS'($urandom);
      cyc(($urandom % 40) == 0, ($urandom % 8) == 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    end
    cyc(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
